// File: rtl/fm_wm_adj_pkg.sv
// Shared types and default geometry for the FM*WM*ADJ result-row reader.
// Widths are the defaults shared with the result memory.
package fm_wm_adj_pkg;

   localparam int DEF_FEATURE_ROWS   = 6;
   localparam int DEF_WEIGHT_COLS    = 3;
   localparam int DEF_DOT_PROD_WIDTH = 16;
   localparam int DEF_FEATURE_WIDTH  = $clog2(DEF_FEATURE_ROWS);
   localparam int DEF_WEIGHT_WIDTH   = $clog2(DEF_WEIGHT_COLS);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } state_e;

endpackage

// File: rtl/fm_wm_adj_row_streamer_if.sv
// Output stream bundle of the row streamer (valid/ready, element plus its coordinates).
// Optional macro ROW_ARGMAX_EN adds the per-row argmax result signals.
interface fm_wm_adj_row_streamer_if
   import fm_wm_adj_pkg::*;
#(
   parameter int DW = DEF_DOT_PROD_WIDTH,
   parameter int FW = DEF_FEATURE_WIDTH,
   parameter int WW = DEF_WEIGHT_WIDTH
);
   logic [DW-1:0] out_data;
   logic [FW-1:0] out_row;
   logic [WW-1:0] out_col;
   logic          out_last;
   logic          out_valid;
   logic          out_ready;
`ifdef ROW_ARGMAX_EN
   logic [WW-1:0] argmax_idx;
   logic          argmax_valid;
`endif

   modport master (
`ifdef ROW_ARGMAX_EN
      output argmax_idx,
      output argmax_valid,
`endif
      output out_data,
      output out_row,
      output out_col,
      output out_last,
      output out_valid,
      input  out_ready
   );

   modport slave (
`ifdef ROW_ARGMAX_EN
      input  argmax_idx,
      input  argmax_valid,
`endif
      input  out_data,
      input  out_row,
      input  out_col,
      input  out_last,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/fm_wm_adj_row_streamer_argmax.sv
// Per-row running signed maximum; reports the column of the largest element
// (lowest column wins ties) together with the row's final accepted beat.
module row_argmax_tracker #(
   parameter int DW   = 16,
   parameter int COLS = 3,
   parameter int WW   = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          hs_i,
   input  logic [DW-1:0] data_i,
   input  logic [WW-1:0] col_i,
   output logic [WW-1:0] argmax_idx_o,
   output logic          argmax_valid_o
);
   localparam logic [WW-1:0] COL_LAST = WW'(COLS - 1);

   logic signed [DW-1:0] max_q, max_d;
   logic [WW-1:0]        idx_q, idx_d;
   logic                 take;

   // compare current element against running max; column 0 always restarts the row
   always_comb begin
      take           = (col_i == '0) || ($signed(data_i) > max_q);
      max_d          = max_q;
      idx_d          = idx_q;
      if (hs_i && take) begin
         max_d = $signed(data_i);
         idx_d = col_i;
      end
      argmax_valid_o = hs_i && (col_i == COL_LAST);
      argmax_idx_o   = argmax_valid_o ? idx_d : idx_q;
   end

   // running max and index registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         max_q <= '0;
         idx_q <= '0;
      end else begin
         max_q <= max_d;
         idx_q <= idx_d;
      end
   end
endmodule

// File: rtl/fm_wm_adj_row_streamer.sv
// Reader-side sequencer for the result row memory: fetches each row into a
// local buffer and streams it one element per valid/ready beat.
// Optional macro ROW_ARGMAX_EN adds a per-row signed argmax tracker.
//
//   state  | meaning
//   IDLE   | waiting for start
//   FETCH  | read_row driven, row captured at the clock edge (one bubble per row)
//   STREAM | buffered row presented, one element per handshake
//   DONE   | one-cycle done pulse, then back to IDLE
module fm_wm_adj_row_streamer
   import fm_wm_adj_pkg::*;
#(
   parameter int FEATURE_ROWS   = DEF_FEATURE_ROWS,
   parameter int WEIGHT_COLS    = DEF_WEIGHT_COLS,
   parameter int DOT_PROD_WIDTH = DEF_DOT_PROD_WIDTH,
   parameter int FEATURE_WIDTH  = $clog2(FEATURE_ROWS),
   parameter int WEIGHT_WIDTH   = $clog2(WEIGHT_COLS)
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         start,
   output logic [FEATURE_WIDTH-1:0]                     read_row,
   input  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]   mem_row_in,
   output logic                                         busy,
   output logic                                         done,
   fm_wm_adj_row_streamer_if.master                     strm
);
   localparam logic [FEATURE_WIDTH-1:0] ROW_LAST = FEATURE_WIDTH'(FEATURE_ROWS - 1);
   localparam logic [WEIGHT_WIDTH-1:0]  COL_LAST = WEIGHT_WIDTH'(WEIGHT_COLS - 1);

   state_e                                     state_q, state_d;
   logic [FEATURE_WIDTH-1:0]                   row_cnt_q, row_cnt_d;
   logic [FEATURE_WIDTH-1:0]                   read_row_q;
   logic [WEIGHT_WIDTH-1:0]                    col_cnt_q, col_cnt_d;
   logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] buf_q;
   logic                                       hs, row_end, mat_end;

   assign hs      = (state_q == STREAM) && strm.out_ready;
   assign row_end = (col_cnt_q == COL_LAST);
   assign mat_end = row_end && (row_cnt_q == ROW_LAST);

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // next-state logic; start only matters in IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = FETCH;
         FETCH:   state_d = STREAM;
         STREAM:  if (hs && row_end) state_d = mat_end ? DONE : FETCH;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // row/column counters advance on accepted beats, explicit compare-and-clear wrap
   always_comb begin
      row_cnt_d = row_cnt_q;
      col_cnt_d = col_cnt_q;
      if (state_q == IDLE) begin
         row_cnt_d = '0;
         col_cnt_d = '0;
      end else if (hs) begin
         if (row_end) begin
            col_cnt_d = '0;
            row_cnt_d = mat_end ? '0 : row_cnt_q + FEATURE_WIDTH'(1);
         end else begin
            col_cnt_d = col_cnt_q + WEIGHT_WIDTH'(1);
         end
      end
   end

   // counters, row buffer capture and held read address
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_cnt_q  <= '0;
         col_cnt_q  <= '0;
         read_row_q <= '0;
         buf_q      <= '0;
      end else begin
         row_cnt_q <= row_cnt_d;
         col_cnt_q <= col_cnt_d;
         if (state_q == FETCH) begin
            buf_q      <= mem_row_in;
            read_row_q <= row_cnt_q;
         end
      end
   end

   // outputs decoded from state; element outputs are zero outside STREAM
   always_comb begin
      read_row       = (state_q == FETCH) ? row_cnt_q : read_row_q;
      busy           = (state_q != IDLE);
      done           = (state_q == DONE);
      strm.out_valid = (state_q == STREAM);
      strm.out_data  = '0;
      strm.out_row   = '0;
      strm.out_col   = '0;
      strm.out_last  = 1'b0;
      if (state_q == STREAM) begin
         strm.out_data = buf_q[col_cnt_q];
         strm.out_row  = row_cnt_q;
         strm.out_col  = col_cnt_q;
         strm.out_last = mat_end;
      end
   end

`ifdef ROW_ARGMAX_EN
   row_argmax_tracker #(
      .DW   (DOT_PROD_WIDTH),
      .COLS (WEIGHT_COLS),
      .WW   (WEIGHT_WIDTH)
   ) u_argmax (
      .clk            (clk),
      .rst            (rst),
      .hs_i           (hs),
      .data_i         (strm.out_data),
      .col_i          (col_cnt_q),
      .argmax_idx_o   (strm.argmax_idx),
      .argmax_valid_o (strm.argmax_valid)
   );
`endif
endmodule
